// File: rtl/r2sdf_bfly_stage.sv
// r2sdf_bfly_stage: radix-2 single-path delay-feedback butterfly stage.
// One complex sample in per accepted cycle. The stage emits butterfly sums (g)
// and differences (h) in natural SDF order, one cycle after the producing shift.
// The twiddle multiply is left to the next stage, which uses out_half/out_idx.
// Optional build macro: R2SDF_ROUND_EN. When it is defined and SCALE=1, the
// halved outputs round half up instead of truncating toward minus infinity.
module r2sdf_bfly_stage #(
    parameter  int DW    = 17,
    parameter  int DEPTH = 16,
    parameter  int SCALE = 1,
    localparam int OW    = (SCALE != 0) ? DW : DW + 1,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    input  logic                 flush,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_r,
    output logic signed [OW-1:0] out_i,
    output logic                 out_half,
    output logic [IW-1:0]        out_idx
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] HALF = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FIRST,
        S_SECOND,
        S_FLUSH
    } state_t;

    state_t                state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [CW-1:0]         cnt_next;
    logic                  in_ready_reg;
    logic                  out_valid_reg;
    logic signed [OW-1:0]  out_r_reg;
    logic signed [OW-1:0]  out_i_reg;
    logic                  out_half_reg;
    logic [IW-1:0]         out_idx_reg;

    // Delay line, one entry per component; entry DEPTH-1 is the tail (B).
    logic signed [DW:0]    dl_r [DEPTH];
    logic signed [DW:0]    dl_i [DEPTH];

    logic                  flush_go;
    logic                  accept;
    logic                  shift_en;
    logic                  produce;
    logic signed [DW:0]    a_r, a_i, b_r, b_i;
    logic signed [DW:0]    sum_r, sum_i, diff_r, diff_i;
    logic signed [DW:0]    sr_r, sr_i;
    logic signed [DW:0]    res_r, res_i;
    logic signed [OW-1:0]  scaled_r, scaled_i;
    logic [IW-1:0]         idx_now;

    assign a_r    = {in_r[DW-1], in_r};
    assign a_i    = {in_i[DW-1], in_i};
    assign b_r    = dl_r[DEPTH-1];
    assign b_i    = dl_i[DEPTH-1];
    assign sum_r  = a_r + b_r;
    assign sum_i  = a_i + b_i;
    assign diff_r = b_r - a_r;
    assign diff_i = b_i - a_i;

    // Handshake and shift qualification. A flush at the frame boundary takes
    // the cycle over: the producer must not present a sample alongside it.
    always_comb begin
        flush_go = flush && (state_reg == S_SECOND) && (cnt_reg == '0);
        accept   = in_valid && in_ready_reg && !flush_go && (state_reg != S_FLUSH);
        shift_en = accept || (state_reg == S_FLUSH);
        produce  = shift_en && ((state_reg == S_FIRST) || (state_reg == S_SECOND) ||
                                (state_reg == S_FLUSH));
        cnt_next = cnt_reg + 1'b1;
    end

    // Per-state choice of what enters the delay line and what leaves the stage.
    always_comb begin
        sr_r  = a_r;
        sr_i  = a_i;
        res_r = b_r;
        res_i = b_i;
        case (state_reg)
            S_FIRST: begin
                sr_r  = diff_r;
                sr_i  = diff_i;
                res_r = sum_r;
                res_i = sum_i;
            end
            S_FLUSH: begin
                sr_r = '0;
                sr_i = '0;
            end
            default: ;
        endcase
    end

    // Output scaling: halve (truncate or round half up) or keep full growth.
    generate
        if (SCALE != 0) begin : g_halve
`ifdef R2SDF_ROUND_EN
            logic signed [DW:0] rnd_r, rnd_i;
            logic               unused_lsb;
            assign rnd_r      = res_r + (DW+1)'(1);
            assign rnd_i      = res_i + (DW+1)'(1);
            assign scaled_r   = rnd_r[DW:1];
            assign scaled_i   = rnd_i[DW:1];
            assign unused_lsb = rnd_r[0] ^ rnd_i[0];
`else
            logic unused_lsb;
            assign scaled_r   = res_r[DW:1];
            assign scaled_i   = res_i[DW:1];
            assign unused_lsb = res_r[0] ^ res_i[0];
`endif
        end else begin : g_full
            assign scaled_r = res_r;
            assign scaled_i = res_i;
        end
    endgenerate

    // Index within the half; with a single-entry line there is only index 0.
    generate
        if (DEPTH > 1) begin : g_idx
            assign idx_now = cnt_reg[CW-2:0];
        end else begin : g_idx0
            assign idx_now = '0;
        end
    endgenerate

    // Delay line: shifts on accepted samples and on every flush cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else if (shift_en) begin
            dl_r[0] <= sr_r;
            dl_i[0] <= sr_i;
            for (int k = 1; k < DEPTH; k++) begin
                dl_r[k] <= dl_r[k-1];
                dl_i[k] <= dl_i[k-1];
            end
        end
    end

    // Control sequencer with registered handshake and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_r_reg     <= '0;
            out_i_reg     <= '0;
            out_half_reg  <= 1'b0;
            out_idx_reg   <= '0;
        end else begin
            out_valid_reg <= produce;
            if (produce) begin
                out_r_reg    <= scaled_r;
                out_i_reg    <= scaled_i;
                out_half_reg <= (state_reg != S_FIRST);
                out_idx_reg  <= idx_now;
            end
            if (flush_go) begin
                state_reg    <= S_FLUSH;
                in_ready_reg <= 1'b0;
            end else if (shift_en) begin
                cnt_reg <= cnt_next;
                case (state_reg)
                    S_IDLE, S_FILL: begin
                        state_reg <= (cnt_next == HALF) ? S_FIRST : S_FILL;
                    end
                    S_FIRST: begin
                        if (cnt_next == '0) state_reg <= S_SECOND;
                    end
                    S_SECOND: begin
                        if (cnt_next == HALF) state_reg <= S_FIRST;
                    end
                    S_FLUSH: begin
                        if (cnt_next == HALF) begin
                            state_reg    <= S_IDLE;
                            cnt_reg      <= '0;
                            in_ready_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_r     = out_r_reg;
    assign out_i     = out_i_reg;
    assign out_half  = out_half_reg;
    assign out_idx   = out_idx_reg;

endmodule
